// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg -- shared definitions for the memory pipeline slice.
//   mem_state_e : request FSM states (IDLE, ACCESS, HALTED)
//   WB_* / M_*  : bit positions inside the WB_in and M_in control bundles
//   word_t      : 16-bit datapath word
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } mem_state_e;

  // WB_in = {RegWrite, MemToReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // M_in = {Halt, MemWrite, MemRead}
  localparam int M_HALT  = 2;
  localparam int M_WRITE = 1;
  localparam int M_READ  = 0;

endpackage

// File: rtl/mem_req_fsm.sv
// ----------------------------------------------------------------------------
// mem_req_fsm -- handshake FSM and data-memory request drivers.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid, m_in        upstream valid and {Halt, MemWrite, MemRead}
//   addr, data            effective address / store data of the instruction
//   mem_ack               memory completion (only honoured in ACCESS)
//   in_ready              1 only in IDLE
//   mem_req, mem_we       request / write-enable, asserted only in ACCESS
//   mem_addr, mem_wdata   held request address and store data
//   halt                  1 while HALTED
//   xfer                  transfer strobe (in_valid && in_ready)
//   ack_edge              1 in the ACCESS cycle that ends with mem_ack
// ----------------------------------------------------------------------------
module mem_req_fsm
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] m_in,
  input  word_t      addr,
  input  word_t      data,
  input  logic       mem_ack,
  output logic       in_ready,
  output logic       mem_req,
  output logic       mem_we,
  output word_t      mem_addr,
  output word_t      mem_wdata,
  output logic       halt,
  output logic       xfer,
  output logic       ack_edge
);

  mem_state_e state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  logic       we_q, we_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Halt dominates any memory bits in the same instruction.
          if (m_in[M_HALT]) begin
            state_d = HALTED;
          end else if (m_in[M_READ] || m_in[M_WRITE]) begin
            state_d = ACCESS;
            addr_d  = addr;
            wdata_d = data;
            // Read+write together is treated as a write.
            we_d    = m_in[M_WRITE];
          end
        end
      end
      ACCESS: begin
        if (mem_ack) state_d = IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halt      = (state_q == HALTED);
  assign xfer      = in_valid && in_ready;
  // An ack is only meaningful while a request is outstanding.
  assign ack_edge  = mem_req && mem_ack;

endmodule

// File: rtl/mem_slice.sv
// ----------------------------------------------------------------------------
// mem_slice -- MEM pipeline stage: captures an EX-stage instruction, performs
// at most one data-memory access, and produces a single-cycle writeback pulse.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid / in_ready            upstream handshake
//   WB_in {RegWrite, MemToReg}, M_in {Halt, MemWrite, MemRead}
//   addr, data, result, flags, rd  instruction operands from EX
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata  data memory
//   wb_valid, wb_regwrite, wb_rd, wb_data                     writeback bundle
//   flags_q                        architectural flags (ALU ops only)
//   halt                           processor halted until reset
//   fwd_valid, fwd_rd, fwd_data    EX forwarding, only with MEM_FWD_EN
// Build option: define MEM_FWD_EN to add the forwarding ports.
// ----------------------------------------------------------------------------
module mem_slice
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] WB_in,
  input  logic [2:0] M_in,
  input  word_t      addr,
  input  word_t      data,
  input  word_t      result,
  input  logic [2:0] flags,
  input  logic [3:0] rd,
  output logic       mem_req,
  output logic       mem_we,
  output word_t      mem_addr,
  output word_t      mem_wdata,
  input  logic       mem_ack,
  input  word_t      mem_rdata,
  output logic       wb_valid,
  output logic       wb_regwrite,
  output logic [3:0] wb_rd,
  output word_t      wb_data,
  output logic [2:0] flags_q,
  output logic       halt
`ifdef MEM_FWD_EN
  ,
  output logic       fwd_valid,
  output logic [3:0] fwd_rd,
  output word_t      fwd_data
`endif
);

  logic xfer, ack_edge;

  mem_req_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .m_in      (M_in),
    .addr      (addr),
    .data      (data),
    .mem_ack   (mem_ack),
    .in_ready  (in_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .halt      (halt),
    .xfer      (xfer),
    .ack_edge  (ack_edge)
  );

  // Captured instruction fields, needed until the memory access completes.
  logic       regwrite_q, regwrite_d;
  logic       memtoreg_q, memtoreg_d;
  logic [3:0] rd_q, rd_d;
  word_t      result_q, result_d;

  logic       wb_valid_q, wb_valid_d;
  logic       wb_regwrite_q, wb_regwrite_d;
  logic [3:0] wb_rd_q, wb_rd_d;
  word_t      wb_data_q, wb_data_d;
  logic [2:0] flags_d;

  logic is_mem;
  assign is_mem = M_in[M_READ] || M_in[M_WRITE];

  always_comb begin
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    rd_d          = rd_q;
    result_d      = result_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    flags_d       = flags_q;

    if (xfer) begin
      regwrite_d = WB_in[WB_REGWRITE];
      memtoreg_d = WB_in[WB_MEMTOREG];
      rd_d       = rd;
      result_d   = result;
      // Plain ALU op: write back immediately and commit flags.
      if (!M_in[M_HALT] && !is_mem) begin
        wb_valid_d    = 1'b1;
        wb_regwrite_d = WB_in[WB_REGWRITE];
        wb_rd_d       = rd;
        wb_data_d     = result;
        flags_d       = flags;
      end
    end

    if (ack_edge) begin
      wb_valid_d    = 1'b1;
      wb_regwrite_d = regwrite_q;
      wb_rd_d       = rd_q;
      // Writes never take read data, even with MemToReg set.
      wb_data_d     = (memtoreg_q && !mem_we) ? mem_rdata : result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      rd_q          <= '0;
      result_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      flags_q       <= '0;
    end else begin
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      rd_q          <= rd_d;
      result_q      <= result_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      flags_q       <= flags_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;

`ifdef MEM_FWD_EN
  assign fwd_valid = wb_valid_q && wb_regwrite_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_mem_slice.sv
module tb_mem_slice;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] WB_in = '0;
  logic [2:0] M_in = '0;
  logic [15:0] addr = '0, data = '0, result = '0;
  logic [2:0] flags = '0;
  logic [3:0] rd = '0;
  logic       mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic       mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic       wb_valid, wb_regwrite;
  logic [3:0] wb_rd;
  logic [15:0] wb_data;
  logic [2:0] flags_q;
  logic       halt;
`ifdef MEM_FWD_EN
  logic       fwd_valid;
  logic [3:0] fwd_rd;
  logic [15:0] fwd_data;
`endif

  mem_slice dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .WB_in(WB_in), .M_in(M_in), .addr(addr), .data(data), .result(result),
    .flags(flags), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q), .halt(halt)
`ifdef MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rd;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] r, input logic w);
    exp_t e;
    e.data = d; e.rd = r; e.rw = w;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [15:0] a,
                       input logic [15:0] dt, input logic [15:0] res, input logic [2:0] fl,
                       input logic [3:0] r);
    in_valid = 1'b1; WB_in = wb; M_in = m; addr = a; data = dt;
    result = res; flags = fl; rd = r;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_rd", wb_rd, e.rd);
        check("wb_regwrite", wb_regwrite, e.rw);
`ifdef MEM_FWD_EN
        check("fwd_valid", fwd_valid, e.rw);
        check("fwd_rd", fwd_rd, e.rd);
        check("fwd_data", fwd_data, e.data);
`endif
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_flags_q", flags_q, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    step();
    rst = 1'b1;
    step();

    // ALU op
    issue(2'b10, 3'b000, 16'h0, 16'h0, 16'h1234, 3'b010, 4'd3);
    push(16'h1234, 4'd3, 1'b1);
    step();
    in_valid = 1'b0;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_flags_q", flags_q, 3'b010);
    check("alu_in_ready", in_ready, 1);
    step();
    check("alu_wb_pulse_one_cycle", wb_valid, 0);
    check("alu_wb_data_hold", wb_data, 16'h1234);

    // Load with three ACCESS cycles
    issue(2'b11, 3'b001, 16'h0040, 16'h0, 16'h5555, 3'b111, 4'd7);
    push(16'hBEEF, 4'd7, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_mem_req", mem_req, 1);
      check("ld_in_ready", in_ready, 0);
      check("ld_mem_addr", mem_addr, 16'h0040);
      check("ld_mem_we", mem_we, 0);
      check("ld_no_wb", wb_valid, 0);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0;
    check("ld_done_req", mem_req, 0);
    check("ld_done_ready", in_ready, 1);
    check("ld_wb_valid", wb_valid, 1);
    check("ld_flags_kept", flags_q, 3'b010);
    step();

    // Store, zero-wait ack
    issue(2'b00, 3'b010, 16'h0010, 16'h00FF, 16'hAAAA, 3'b111, 4'd2);
    push(16'hAAAA, 4'd2, 1'b0);
    step();
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    check("st_mem_req", mem_req, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_wdata", mem_wdata, 16'h00FF);
    check("st_mem_addr", mem_addr, 16'h0010);
    step();
    mem_ack = 1'b0;
    check("st_req_one_cycle", mem_req, 0);
    check("st_we_dropped", mem_we, 0);
    check("st_flags_kept", flags_q, 3'b010);
    step();

    // Read+write together is a write, read data ignored
    issue(2'b11, 3'b011, 16'h0020, 16'h0042, 16'h7777, 3'b000, 4'd9);
    push(16'h7777, 4'd9, 1'b1);
    step();
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    check("rw_mem_we", mem_we, 1);
    step();
    mem_ack = 1'b0;
    step();

    // Ack outside ACCESS is ignored
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    check("idle_ack_no_req", mem_req, 0);
    check("idle_ack_no_wb", wb_valid, 0);
    mem_ack = 1'b0;
    step();

    // Reset in the second ACCESS cycle
    issue(2'b11, 3'b001, 16'h0080, 16'h0, 16'h0, 3'b000, 4'd4);
    step();
    in_valid = 1'b0;
    check("ra_first_cycle_req", mem_req, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("ra_req_async_drop", mem_req, 0);
    check("ra_in_ready", in_ready, 1);
    check("ra_wb_valid", wb_valid, 0);
    check("ra_flags_cleared", flags_q, 0);
    step();
    rst = 1'b1;
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("ra_not_resumed", mem_req, 0);
    check("ra_wb_never", wb_valid, 0);

    // Halt with MemRead set
    issue(2'b10, 3'b101, 16'h0050, 16'h0, 16'h3333, 3'b001, 4'd1);
    step();
    for (int i = 0; i < 100; i++) begin
      mem_ack = (i % 7 == 3);
      in_valid = 1'b1;
      check("halt_req", mem_req, 0);
      check("halt_flag", halt, 1);
      check("halt_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    check("halt_flags_kept", flags_q, 0);
    rst = 1'b0;
    #1;
    check("halt_rst_halt", halt, 0);
    check("halt_rst_ready", in_ready, 1);
    step();
    rst = 1'b1;
    step();

    // Back-to-back ALU ops to rd=5
    issue(2'b10, 3'b000, 16'h0, 16'h0, 16'h0A0A, 3'b100, 4'd5);
    push(16'h0A0A, 4'd5, 1'b1);
    step();
    issue(2'b10, 3'b000, 16'h0, 16'h0, 16'h0B0B, 3'b001, 4'd5);
    push(16'h0B0B, 4'd5, 1'b1);
    check("b2b_first_data", wb_data, 16'h0A0A);
`ifdef MEM_FWD_EN
    check("b2b_fwd_valid", fwd_valid, 1);
    check("b2b_fwd_rd", fwd_rd, 5);
    check("b2b_fwd_data", fwd_data, 16'h0A0A);
`endif
    step();
    in_valid = 1'b0;
    check("b2b_second_data", wb_data, 16'h0B0B);
    check("b2b_flags", flags_q, 3'b001);
    step();
    step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_slice.md
MEM_SLICE -- requirements
Module: mem_slice

Interface
REQ-001 clk  in  1  single clock; all state rising-edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  EX stage presents a valid instruction.
REQ-004 in_ready  out  1  stage can accept; upstream stalls when 0.
REQ-005 WB_in  in  2  {RegWrite, MemToReg}.
REQ-006 M_in  in  3  {Halt, MemWrite, MemRead}.
REQ-007 addr, data, result  in  16 each  effective address, store data, ALU result.
REQ-008 flags  in  3  {zero, neg, overflow} from ALU.
REQ-009 rd  in  4  destination register.
REQ-010 mem_req, mem_we  out  1 each  data-memory request and write-enable.
REQ-011 mem_addr, mem_wdata  out  16 each  held request address and data.
REQ-012 mem_ack  in  1; mem_rdata  in  16  memory completion and read data.
REQ-013 wb_valid, wb_regwrite  out  1 each; wb_rd  out  4; wb_data  out  16  writeback bundle.
REQ-014 flags_q  out  3  architectural flag register.
REQ-015 halt  out  1  processor halted.
REQ-016 fwd_valid  out  1; fwd_rd  out  4; fwd_data  out  16  present only with MEM_FWD_EN.

Function
REQ-017 The transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; the inputs are captured into internal registers.
REQ-018 The FSM SHALL have states IDLE, ACCESS and HALTED; in_ready = 1 only in IDLE.
REQ-019 On a non-memory, non-halt transfer, the block SHALL stay in IDLE, drive wb_valid = 1 for exactly the next cycle with wb_data = result, and load flags_q <= flags on the same edge.
REQ-020 On a transfer with MemRead or MemWrite, the block SHALL enter ACCESS; flags_q is left unchanged.
REQ-021 In ACCESS, mem_req = 1 with stable mem_addr, mem_wdata and mem_we until the edge on which mem_ack = 1; an ack in the first ACCESS cycle SHALL be honoured.
REQ-022 When MemRead and MemWrite are both set, the access SHALL be a write (mem_we = 1) and mem_rdata SHALL be ignored.
REQ-023 On the ack edge, the block SHALL return to IDLE and pulse wb_valid the next cycle; wb_data = MemToReg ? mem_rdata : result, captured on the ack edge.
REQ-024 Load latency SHALL be 1 + (ACCESS cycles): a zero-wait ack yields wb_valid 2 cycles after the transfer.
REQ-025 mem_ack outside ACCESS SHALL be ignored.
REQ-026 A transfer with Halt set SHALL enter HALTED; no memory access and no wb_valid occur, even if MemRead or MemWrite is set.
REQ-027 In HALTED, halt = 1 and in_ready = 0 until reset.
REQ-028 wb_regwrite and wb_rd SHALL reflect the captured instruction, and SHALL be qualified by wb_valid.
REQ-029 When wb_valid = 0, wb_data, wb_rd and wb_regwrite SHALL hold their last values.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE with every output 0 except in_ready = 1, including during ACCESS (mem_req drops asynchronously).
REQ-031 Deassertion SHALL take effect on the next clk edge; no pending access is resumed.

Configuration
REQ-032 With MEM_FWD_EN defined, fwd_valid SHALL equal wb_valid && wb_regwrite, and fwd_rd/fwd_data SHALL mirror wb_rd/wb_data for EX-stage forwarding.
REQ-033 Without MEM_FWD_EN, the fwd_* ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package mem_pkg SHALL hold the state enum (IDLE, ACCESS, HALTED), the bit-index localparams for WB_in and M_in, and the 16-bit word type.
REQ-035 The request FSM and the mem_* drivers SHALL be one sub-module, mem_req_fsm; the capture and writeback registers SHALL reside in mem_slice.

Verification
REQ-036 ALU op: result=16'h1234, flags=3'b010, rd=3, RegWrite=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, flags_q=3'b010.
REQ-037 Load addr=16'h0040, ack after 3 ACCESS cycles, rdata=16'hBEEF, MemToReg=1 -> mem_req high 3 cycles, in_ready=0 throughout, then wb_data=16'hBEEF.
REQ-038 Store addr=16'h0010, data=16'h00FF, zero-wait ack -> mem_we=1, mem_wdata=16'h00FF for one cycle, wb_valid with wb_regwrite=0, flags_q unchanged.
REQ-039 rst asserted in the second ACCESS cycle -> mem_req=0 within the same cycle, wb_valid never asserted, in_ready=1.
REQ-040 Halt with MemRead set -> mem_req stays 0, halt=1, in_ready=0 held for 100 cycles; spurious mem_ack is ignored.
REQ-041 With MEM_FWD_EN, back-to-back ALU ops to rd=5 -> fwd_valid=1, fwd_rd=5, fwd_data equals the first result in the cycle after its transfer.
